// File: rtl/counter_bank.sv
// counter_bank: bank of programmable up/down wrap/saturate counters with optional carry cascade
module counter_bank #(
    parameter int NUM_CH  = 2,
    parameter int WIDTH   = 4,
    parameter int CASCADE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic [NUM_CH-1:0]       i_dir,
    input  logic [NUM_CH-1:0]       i_sat,
    input  logic [NUM_CH-1:0]       i_load,
    input  logic [NUM_CH*WIDTH-1:0] i_load_val,
    input  logic [NUM_CH*WIDTH-1:0] i_max,
    output logic [NUM_CH*WIDTH-1:0] o_cnt,
    output logic [NUM_CH-1:0]       o_tc
);
    logic [WIDTH-1:0]  r_cnt [NUM_CH];
    logic [NUM_CH-1:0] r_tc;
    logic [WIDTH-1:0]  w_max [NUM_CH];
    logic [WIDTH-1:0]  w_ld  [NUM_CH];
    logic [NUM_CH-1:0] w_term;
    logic [NUM_CH-1:0] w_step;

    always_comb begin
        w_step[0] = i_en;
        for (int k = 0; k < NUM_CH; k++) begin
            w_max[k]  = i_max[k*WIDTH +: WIDTH];
            w_ld[k]   = (i_load_val[k*WIDTH +: WIDTH] > w_max[k]) ? w_max[k] : i_load_val[k*WIDTH +: WIDTH];
            w_term[k] = i_dir[k] ? (r_cnt[k] >= w_max[k]) : (r_cnt[k] == '0);
            o_cnt[k*WIDTH +: WIDTH] = r_cnt[k];
        end
        // Carry ripples combinationally so a whole chain wraps on one edge
        for (int k = 1; k < NUM_CH; k++)
            w_step[k] = (CASCADE != 0) ? (i_en & w_step[k-1] & w_term[k-1] & ~i_load[k-1]) : i_en;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CH; k++)
                r_cnt[k] <= '0;
            r_tc <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (i_load[k]) begin
                    r_cnt[k] <= w_ld[k];
                    r_tc[k]  <= 1'b0;
                end else if (w_step[k] && w_term[k]) begin
                    r_cnt[k] <= i_sat[k] ? r_cnt[k] : (i_dir[k] ? '0 : w_max[k]);
                    r_tc[k]  <= 1'b1;
                end else if (w_step[k]) begin
                    r_cnt[k] <= i_dir[k] ? r_cnt[k] + 1'b1 : r_cnt[k] - 1'b1;
                    r_tc[k]  <= 1'b0;
                end else begin
                    r_tc[k]  <= 1'b0;
                end
            end
        end
    end

    assign o_tc = r_tc;
endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: directed scoreboard bench for a two-digit decade cascade
module tb_counter_bank;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_en = 1'b0;
    logic [1:0] i_dir = 2'b11;
    logic [1:0] i_sat = 2'b00;
    logic [1:0] i_load = 2'b00;
    logic [7:0] i_load_val = 8'h00;
    logic [7:0] i_max = 8'h99;
    logic [7:0] o_cnt;
    logic [1:0] o_tc;

    typedef struct {
        string      nm;
        logic [7:0] cnt;
        logic [1:0] tc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    counter_bank #(.NUM_CH(2), .WIDTH(4), .CASCADE(1)) dut (
        .clk(clk), .rst(rst), .i_en(i_en), .i_dir(i_dir), .i_sat(i_sat),
        .i_load(i_load), .i_load_val(i_load_val), .i_max(i_max),
        .o_cnt(o_cnt), .o_tc(o_tc)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int n);
        logic [3:0] hi, lo;
        hi = 4'((n / 10) % 10);
        lo = 4'(n % 10);
        return {hi, lo};
    endfunction

    task automatic tick(input string nm, input logic [7:0] ec, input logic [1:0] et, input bit chk);
        exp_t e;
        @(posedge clk);
        #1;
        if (chk) begin
            e.nm  = nm;
            e.cnt = ec;
            e.tc  = et;
            q.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick("reset", 8'h00, 2'b00, 1'b1);
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (o_cnt !== e.cnt || o_tc !== e.tc) begin
                errors++;
                $display("FAIL %s: got cnt=%h tc=%b, expected cnt=%h tc=%b", e.nm, o_cnt, o_tc, e.cnt, e.tc);
            end
        end
    end

    initial begin
        i_en = 1'b1;
        for (int n = 0; n < 100; n++) tick("long_reset", 8'h00, 2'b00, 1'b1);
        rst = 1'b1;
        for (int n = 1; n <= 10; n++) tick("ten_en", bcd(n), {1'b0, n == 10}, 1'b1);

        do_reset();
        for (int n = 1; n <= 100; n++)
            tick("hundred_en", bcd(n % 100), {n % 100 == 0, n % 10 == 0}, 1'b1);

        do_reset();
        i_dir = 2'b00;
        tick("down_wrap", 8'h99, 2'b11, 1'b1);
        tick("down_dec", 8'h98, 2'b00, 1'b1);
        i_dir = 2'b11;

        do_reset();
        i_sat = 2'b01;
        i_max = 8'h95;
        for (int n = 1; n <= 8; n++)
            tick("sat", n <= 5 ? bcd(n) : {4'(n - 5), 4'd5}, {1'b0, n >= 6}, 1'b1);
        i_sat = 2'b00;
        i_max = 8'h99;

        do_reset();
        i_en = 1'b0;
        i_load = 2'b01;
        i_load_val = 8'hFC;
        tick("load_clamp", 8'h09, 2'b00, 1'b1);
        i_en = 1'b1;
        i_load_val = 8'hF3;
        tick("load_beats_carry", 8'h03, 2'b00, 1'b1);
        i_load = 2'b00;

        do_reset();
        i_max = 8'h90;
        for (int n = 1; n <= 3; n++) tick("max_zero", {4'(n), 4'd0}, 2'b01, 1'b1);
        i_max = 8'h99;

        do_reset();
        for (int n = 1; n <= 7; n++) tick("pre_oor", bcd(n), 2'b00, n == 7);
        i_max = 8'h95;
        tick("oor_up_wrap", 8'h10, 2'b01, 1'b1);
        i_max = 8'h99;

        do_reset();
        for (int n = 1; n <= 47; n++) tick("to_47", bcd(n), {1'b0, n % 10 == 0}, n == 47);
        rst = 1'b0;
        i_load = 2'b11;
        i_load_val = 8'hFF;
        tick("reset_over_load", 8'h00, 2'b00, 1'b1);
        rst = 1'b1;
        i_load = 2'b00;
        for (int n = 1; n <= 3; n++) tick("resume", bcd(n), 2'b00, 1'b1);
        i_en = 1'b0;
        tick("idle_hold", 8'h03, 2'b00, 1'b1);

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d pending, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/counter_bank.md
Name: counter_bank

Overview:
- Parametrised bank of NUM_CH independent or cascaded counters, each WIDTH bits wide.
- Each channel has a programmable terminal value, selectable direction and wrap/saturate mode, synchronous load, and a terminal-count pulse.
- Generalises the fixed two-channel 4-bit counter pair, e.g. a two-digit decade counter with CASCADE=1 and i_max=9 per channel.
- Used as the counting/timebase primitive feeding display and timing logic.

Parameters:
- NUM_CH, 2: number of counter channels, 1..8.
- WIDTH, 4: bits per channel counter, 2..16.
- CASCADE, 1: 1 = channel k>0 steps only on the carry/borrow from channel k-1; 0 = all channels step on i_en.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- i_en  in  1  global count enable.
- i_dir  in  NUM_CH  per-channel direction: 1 = up, 0 = down.
- i_sat  in  NUM_CH  per-channel mode: 1 = saturate at terminal, 0 = wrap.
- i_load  in  NUM_CH  per-channel synchronous load strobe.
- i_load_val  in  NUM_CH*WIDTH  load values; channel k at bits [k*WIDTH +: WIDTH].
- i_max  in  NUM_CH*WIDTH  per-channel upper terminal value; count range is 0..i_max.
- o_cnt  out  NUM_CH*WIDTH  registered count values, packed like i_max.
- o_tc  out  NUM_CH  registered terminal-count pulse per channel.

Behaviour:
- Reset (rst=0 at a clock edge): all o_cnt=0, all o_tc=0. Reset overrides load and step. A reset asserted mid-count takes effect on that edge.
- Terminal detect (combinational, per channel):
  - up: term_k = (cnt_k >= max_k)
  - down: term_k = (cnt_k == 0)
- Step condition:
  - step_0 = i_en.
  - CASCADE=1: step_k = i_en & step_(k-1) & term_(k-1) & ~i_load[k-1], for k>0.
  - CASCADE=0: step_k = i_en.
- Per-channel next state, in priority order:
  1. i_load[k]=1: cnt_k <= min(load_val_k, max_k); o_tc[k] <= 0. Load wins over step.
  2. step_k and term_k, wrap mode: cnt_k <= 0 if counting up, max_k if counting down; o_tc[k] <= 1.
  3. step_k and term_k, saturate mode: cnt_k holds; o_tc[k] <= 1 on every such step.
  4. step_k, not term_k: cnt_k <= cnt_k + 1 (up) or cnt_k - 1 (down), modulo 2^WIDTH; o_tc[k] <= 0.
  5. Otherwise: cnt_k holds; o_tc[k] <= 0.
- Latency: o_cnt and o_tc update on the same edge. o_tc is high for exactly one cycle per terminal step, in the cycle the wrapped or held value is visible.
- Out-of-range count: if i_max is lowered below the current count, an up-count treats the channel as terminal, so the next step wraps to 0 or holds. A down-count decrements normally.
- i_max=0: the channel is terminal on every step; o_tc is continuously high while stepping.
- Direction change takes effect on the next step; no pipeline state is held.
- Cascade carry is combinational within one cycle, so all channels in a chain wrap on the same edge.
- A load on channel k-1 suppresses carry into channel k that cycle.
- i_dir, i_sat, i_load_val and i_max are sampled only at the edge where they are used.

Test Plan:
- Setup for all scenarios unless stated: NUM_CH=2, WIDTH=4, CASCADE=1, i_max={9,9}, up, wrap.
- Hold rst=0 for 100 cycles with i_en=1, then release and apply 10 enables → o_cnt = {1,0}; o_tc[0] pulses once, on the 10th edge.
- 100 consecutive enables from 0 → o_cnt = {0,0} after the 100th edge; o_tc[0] and o_tc[1] both high on that edge only.
- Both channels down, start at {0,0}, 1 enable → o_cnt = {9,9}, o_tc = 2'b11; next enable → {9,8}, o_tc = 2'b00.
- Channel 0 saturate, i_max0=5, up, 8 enables → cnt0 = 5 from the 5th edge onward; o_tc[0] high on edges 6, 7 and 8; channel 1 increments by 3.
- Load channel 0 with 12 (i_max0=9) → cnt0 = 9. Next cycle assert i_load[0]=1, i_load_val=3, i_en=1 → cnt0 = 3, cnt1 unchanged, o_tc = 0.
- Mid-count at {4,7}, drive rst=0 for one edge with i_en=1 and i_load=2'b11 → o_cnt = {0,0}, o_tc = 0; counting resumes from 0 after release.
